// File: rtl/mips_io_responder_pkg.sv
// Shared constants for the MIPS memory-mapped I/O responder: bus addresses,
// the power-on expected result, and bit positions of the status word.
package mips_io_pkg;

  localparam logic [7:0] OUT_ADR  = 8'hFF;
  localparam logic [7:0] STAT_ADR = 8'hFE;
  localparam logic [7:0] EXP_ADR  = 8'hFD;
  localparam logic [7:0] EXPECTED = 8'h0D;

  // Status word layout; bits [2:0] carry the FIFO occupancy.
  localparam int STAT_FULL  = 3;
  localparam int STAT_EMPTY = 4;
  localparam int STAT_OVF   = 5;
  localparam int STAT_DONE  = 6;
  localparam int STAT_PASS  = 7;

endpackage

// File: rtl/mips_io_responder_if.sv
// Processor bus, output stream and result flags of the I/O responder.
// The slave modport is the responder; the master modport is the processor,
// consumer and observer side taken together.
interface mips_io_if #(
  parameter int WIDTH = 8
);

  logic             memread;
  logic             memwrite;
  logic [WIDTH-1:0] adr;
  logic [WIDTH-1:0] writedata;
  logic             iosel;
  logic [WIDTH-1:0] iodata;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             done;
  logic             pass;
  logic             fail;
  logic             overflow;

  modport slave (
    input  memread, memwrite, adr, writedata, out_ready,
    output iosel, iodata, out_valid, out_data, done, pass, fail, overflow
  );

  modport master (
    output memread, memwrite, adr, writedata, out_ready,
    input  iosel, iodata, out_valid, out_data, done, pass, fail, overflow
  );

endinterface

// File: rtl/mips_io_responder_io_fifo.sv
// DEPTH x WIDTH synchronous FIFO with an occupancy count. The caller only
// asserts push when there is room (or a pop frees a slot the same edge) and
// only asserts pop when non-empty. DEPTH must be a power of two, at least 2.
module io_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wptr;
  logic [PW-1:0]    rptr;

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
  assign rdata = mem[rptr];

  // Storage is data only and needs no reset; stale entries are never visible.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= wdata;
  end

  // Pointers wrap naturally modulo DEPTH; count tracks push minus pop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (!push && pop) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/mips_io_responder.sv
// Memory-mapped I/O responder for the top of the 8-bit MIPS address space:
// OUT_ADR stores feed an output FIFO and the first one is checked against an
// expected register; STAT_ADR/EXP_ADR loads return data one cycle later.
module mips_io_responder #(
  parameter int               WIDTH    = 8,
  parameter int               DEPTH    = 4,
  parameter logic [WIDTH-1:0] OUT_ADR  = mips_io_pkg::OUT_ADR,
  parameter logic [WIDTH-1:0] STAT_ADR = mips_io_pkg::STAT_ADR,
  parameter logic [WIDTH-1:0] EXP_ADR  = mips_io_pkg::EXP_ADR,
  parameter logic [WIDTH-1:0] EXPECTED = mips_io_pkg::EXPECTED
) (
  input  logic      clk,
  input  logic      reset,
  mips_io_if.slave  bus
);

  import mips_io_pkg::*;

  localparam int CW = $clog2(DEPTH) + 1;

  logic             st_out;
  logic             st_stat;
  logic             st_exp;
  logic             pop;
  logic             push;
  logic             drop;
  logic             full;
  logic             empty;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] head;
  logic [WIDTH-1:0] exp_q;
  logic             done_q;
  logic             pass_q;
  logic             fail_q;
  logic             ovf_q;
  logic [WIDTH-1:0] stat;
  logic             rd_sel;
  logic [WIDTH-1:0] rd_data;
  logic             iosel_p1;
  logic [WIDTH-1:0] iodata_p1;

  // Store decode; a full FIFO still accepts a push when a pop frees a slot.
  always_comb begin
    st_out  = bus.memwrite && (bus.adr == OUT_ADR);
    st_stat = bus.memwrite && (bus.adr == STAT_ADR);
    st_exp  = bus.memwrite && (bus.adr == EXP_ADR);
    pop     = !empty && bus.out_ready;
    push    = st_out && (!full || pop);
    drop    = st_out && full && !pop;
  end

  io_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .wdata (bus.writedata),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  // Sticky result flags, overflow (set beats clear) and the expected register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      exp_q  <= EXPECTED;
      done_q <= 1'b0;
      pass_q <= 1'b0;
      fail_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      if (st_exp) exp_q <= bus.writedata;
      if (st_out && !done_q) begin
        done_q <= 1'b1;
        pass_q <= (bus.writedata == exp_q);
        fail_q <= (bus.writedata != exp_q);
      end
      if (drop)                               ovf_q <= 1'b1;
      else if (st_stat && bus.writedata[5])   ovf_q <= 1'b0;
    end
  end

  // Status word and load mux, built from pre-edge state.
  always_comb begin
    stat             = '0;
    stat[2:0]        = 3'(count);
    stat[STAT_FULL]  = full;
    stat[STAT_EMPTY] = empty;
    stat[STAT_OVF]   = ovf_q;
    stat[STAT_DONE]  = done_q;
    stat[STAT_PASS]  = pass_q;
    rd_sel           = 1'b0;
    rd_data          = '0;
    if (bus.memread && !bus.memwrite) begin
      if (bus.adr == STAT_ADR) begin
        rd_sel  = 1'b1;
        rd_data = stat;
      end else if (bus.adr == EXP_ADR) begin
        rd_sel  = 1'b1;
        rd_data = exp_q;
      end else if (bus.adr == OUT_ADR) begin
        rd_sel  = 1'b1;
      end
    end
  end

  // Load response stage: one cycle of latency, like the data memory.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      iosel_p1  <= 1'b0;
      iodata_p1 <= '0;
    end else begin
      iosel_p1  <= rd_sel;
      iodata_p1 <= rd_data;
    end
  end

  assign bus.iosel     = iosel_p1;
  assign bus.iodata    = iodata_p1;
  assign bus.out_valid = !empty;
  assign bus.out_data  = head;
  assign bus.done      = done_q;
  assign bus.pass      = pass_q;
  assign bus.fail      = fail_q;
  assign bus.overflow  = ovf_q;

endmodule
